// File: rtl/lcd_link_core.sv
// lcd_link_core
//   Back-end for an ST7565-class LCD. It holds the init-command ROM, a 1024x8
//   frame buffer and the byte serializer that drives the sda/cs pair. The
//   external controller FSM supplies the ROM and RAM addresses, the 0..19 slot
//   counter (sck = scnt[0]) and the byte to send.
//
// Ports
//   sys_clk     system clock
//   reset       asynchronous, active-high reset
//   addr_inst   init-ROM address             -> inst_out   (combinational)
//   addr_write  RAM write address, data_write, write_en (active high)
//   addr_read   RAM read address             -> data_read  (1-cycle latency)
//   scnt        slot counter 0..SLOT_LEN-1, +1 per clock
//   lcd_data    byte to serialize, valid from scnt==1 of each slot
//   en          serializer enable, active low, sampled at scnt==1 only
//   sda         serial data, MSB first (registered)
//   cs          chip select, active low (registered)
module lcd_link_core #(
  parameter int unsigned INIT_LEN  = 14,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned SLOT_LEN  = 20
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [3:0] addr_inst,
  output logic [7:0] inst_out,
  input  logic [9:0] addr_write,
  input  logic [7:0] data_write,
  input  logic       write_en,
  input  logic [9:0] addr_read,
  output logic [7:0] data_read,
  input  logic [4:0] scnt,
  input  logic [7:0] lcd_data,
  input  logic       en,
  output logic       sda,
  output logic       cs
);

  // ---------------------------------------------------------------------------
  // Init-command ROM. Addresses past the command list return NOP (E3).
  // ---------------------------------------------------------------------------
  logic [7:0] rom_data;

  always_comb begin
    rom_data = 8'hE3;
    unique case (addr_inst)
      4'd0:    rom_data = 8'hE2; // software reset
      4'd1:    rom_data = 8'hA2; // bias 1/9
      4'd2:    rom_data = 8'hA0; // ADC normal
      4'd3:    rom_data = 8'hC8; // COM reverse
      4'd4:    rom_data = 8'h2C; // booster on
      4'd5:    rom_data = 8'h2E; // regulator on
      4'd6:    rom_data = 8'h2F; // follower on
      4'd7:    rom_data = 8'h24; // resistor ratio
      4'd8:    rom_data = 8'h81; // volume command
      4'd9:    rom_data = 8'h20; // volume value
      4'd10:   rom_data = 8'h40; // start line 0
      4'd11:   rom_data = 8'hA6; // normal display
      4'd12:   rom_data = 8'hA4; // all-points off
      4'd13:   rom_data = 8'hAF; // display on
      default: rom_data = 8'hE3;
    endcase
    if (32'(addr_inst) >= INIT_LEN) begin
      rom_data = 8'hE3;
    end
  end

  assign inst_out = rom_data;

  // ---------------------------------------------------------------------------
  // Frame buffer. Contents survive reset; only the read register is cleared.
  // A same-address read/write returns the byte stored before the write.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [RAM_DEPTH] = '{default: 8'h00};
  logic [7:0] data_read_d, data_read_q;

  always_ff @(posedge sys_clk) begin
    if (write_en) begin
      mem[addr_write] <= data_write;
    end
  end

  always_comb begin
    data_read_d = mem[addr_read];
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      data_read_q <= '0;
    end else begin
      data_read_q <= data_read_d;
    end
  end

  assign data_read = data_read_q;

  // ---------------------------------------------------------------------------
  // Serializer. One byte per slot: load at scnt==1, shift on odd scnt 3..15,
  // release cs at scnt==17.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } ser_state_t;

  ser_state_t state_d, state_q;
  logic [7:0] shreg_d, shreg_q;
  logic       sda_d, sda_q;
  logic       cs_d, cs_q;
  logic       scnt_in_slot;
  logic       shift_slot;

  always_comb begin
    scnt_in_slot = (32'(scnt) < SLOT_LEN);
    shift_slot   = scnt[0] && (scnt >= 5'd3) && (scnt <= 5'd15);
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    sda_d   = sda_q;
    cs_d    = cs_q;

    if (scnt_in_slot) begin
      if (scnt == 5'd1) begin
        // scnt==1 always closes whatever was in flight, which also ends a
        // byte that lost its scnt==17 to a controller restart.
        if (!en) begin
          state_d = S_ACTIVE;
          shreg_d = lcd_data;
          sda_d   = lcd_data[7];
          cs_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
          cs_d    = 1'b1;
        end
      end else if (state_q == S_ACTIVE) begin
        if (scnt == 5'd17) begin
          state_d = S_IDLE;
          cs_d    = 1'b1;
        end else if (shift_slot) begin
          // sda takes the next bit straight from the pre-shift register.
          shreg_d = {shreg_q[6:0], 1'b0};
          sda_d   = shreg_q[6];
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      sda_q   <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sda_q   <= sda_d;
      cs_q    <= cs_d;
    end
  end

  assign sda = sda_q;
  assign cs  = cs_q;

endmodule

// File: tb/tb_lcd_link_core.sv
// tb_lcd_link_core
//   Self-checking bench for lcd_link_core: table-driven ROM vectors, a read
//   scoreboard for the frame buffer and slot-by-slot serializer expectations.
module tb_lcd_link_core;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [3:0] addr_inst;
  logic [7:0] inst_out;
  logic [9:0] addr_write;
  logic [7:0] data_write;
  logic       write_en;
  logic [9:0] addr_read;
  logic [7:0] data_read;
  logic [4:0] scnt;
  logic [7:0] lcd_data;
  logic       en;
  logic       sda;
  logic       cs;

  lcd_link_core #(
    .INIT_LEN (14),
    .RAM_DEPTH(1024),
    .SLOT_LEN (20)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .addr_inst (addr_inst),
    .inst_out  (inst_out),
    .addr_write(addr_write),
    .data_write(data_write),
    .write_en  (write_en),
    .addr_read (addr_read),
    .data_read (data_read),
    .scnt      (scnt),
    .lcd_data  (lcd_data),
    .en        (en),
    .sda       (sda),
    .cs        (cs)
  );

  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] model_mem [1024];
  logic [7:0] rd_q [$];
  logic [1:0] ser_q [$];
  logic       cur_sda;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rom_vec_t;

  rom_vec_t rom_tab [16];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One RAM cycle: expected read value is the model's byte before this write.
  task automatic ram_cycle(input logic we, input logic [9:0] wa, input logic [7:0] wd,
                           input logic [9:0] ra);
    logic [7:0] e;
    @(negedge sys_clk);
    write_en   = we;
    addr_write = wa;
    data_write = wd;
    addr_read  = ra;
    rd_q.push_back(model_mem[ra]);
    if (we) model_mem[wa] = wd;
    @(posedge sys_clk);
    #1;
    write_en = 1'b0;
    e = rd_q.pop_front();
    check($sformatf("data_read@%0d", ra), data_read, e);
  endtask

  // One serializer cycle with the expected cs/sda after the edge.
  task automatic cyc(input logic [4:0] s, input logic e, input logic [7:0] d,
                     input logic ecs, input logic esda);
    logic [1:0] x;
    @(negedge sys_clk);
    scnt     = s;
    en       = e;
    lcd_data = d;
    ser_q.push_back({ecs, esda});
    cur_sda = esda;
    @(posedge sys_clk);
    #1;
    x = ser_q.pop_front();
    check($sformatf("cs@scnt%0d", s), {7'd0, cs}, {7'd0, x[1]});
    check($sformatf("sda@scnt%0d", s), {7'd0, sda}, {7'd0, x[0]});
  endtask

  // Drive scnt first_s..last_s of a slot; en_at1 is what scnt==1 samples.
  task automatic run_slot(input logic en_at1, input logic en_other, input logic [7:0] b,
                          input int first_s, input int last_s);
    logic ecs, esda, e;
    for (int s = first_s; s <= last_s; s++) begin
      e    = (s == 1) ? en_at1 : en_other;
      ecs  = 1'b1;
      esda = cur_sda;
      if (!en_at1 && s >= 1) begin
        if (s <= 16) begin
          ecs  = 1'b0;
          esda = b[7 - (s - 1) / 2];
        end else begin
          esda = b[0];
        end
      end
      cyc(5'(s), e, b, ecs, esda);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rom_tab[0]  = '{4'd0,  8'hE2};  rom_tab[1]  = '{4'd1,  8'hA2};
    rom_tab[2]  = '{4'd2,  8'hA0};  rom_tab[3]  = '{4'd3,  8'hC8};
    rom_tab[4]  = '{4'd4,  8'h2C};  rom_tab[5]  = '{4'd5,  8'h2E};
    rom_tab[6]  = '{4'd6,  8'h2F};  rom_tab[7]  = '{4'd7,  8'h24};
    rom_tab[8]  = '{4'd8,  8'h81};  rom_tab[9]  = '{4'd9,  8'h20};
    rom_tab[10] = '{4'd10, 8'h40};  rom_tab[11] = '{4'd11, 8'hA6};
    rom_tab[12] = '{4'd12, 8'hA4};  rom_tab[13] = '{4'd13, 8'hAF};
    rom_tab[14] = '{4'd14, 8'hE3};  rom_tab[15] = '{4'd15, 8'hE3};
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;

    reset      = 1'b1;
    addr_inst  = '0;
    addr_write = '0;
    data_write = '0;
    write_en   = 1'b0;
    addr_read  = '0;
    scnt       = '0;
    lcd_data   = '0;
    en         = 1'b1;
    #1;
    check("reset cs", {7'd0, cs}, 8'h01);
    check("reset sda", {7'd0, sda}, 8'h00);
    check("reset data_read", data_read, 8'h00);

    // ROM is combinational: settle a moment after each address change.
    for (int i = 0; i < 16; i++) begin
      addr_inst = rom_tab[i].addr;
      #1;
      check($sformatf("rom@%0d", i), inst_out, rom_tab[i].exp);
    end

    @(negedge sys_clk);
    reset = 1'b0;

    ram_cycle(1'b1, 10'd0,    8'hA5, 10'd0);
    ram_cycle(1'b1, 10'd1023, 8'h3C, 10'd0);
    ram_cycle(1'b0, 10'd0,    8'h00, 10'd1023);
    ram_cycle(1'b0, 10'd0,    8'h00, 10'd0);
    ram_cycle(1'b1, 10'd5,    8'h11, 10'd1023);
    ram_cycle(1'b1, 10'd5,    8'h55, 10'd5);
    ram_cycle(1'b0, 10'd0,    8'h00, 10'd5);

    cur_sda = 1'b0;
    run_slot(1'b0, 1'b0, 8'hB4, 0, 19);
    // en released mid-slot must not abort the byte
    run_slot(1'b0, 1'b1, 8'h81, 0, 19);
    run_slot(1'b1, 1'b1, 8'h00, 0, 19);
    // out-of-slot scnt values are ignored even with en low
    cyc(5'd25, 1'b0, 8'hFF, 1'b1, cur_sda);
    cyc(5'd31, 1'b0, 8'hFF, 1'b1, cur_sda);

    // controller restart at scnt 9: byte stays open until the next scnt==1
    run_slot(1'b0, 1'b0, 8'hC3, 0, 9);
    cyc(5'd0, 1'b1, 8'hC3, 1'b0, cur_sda);
    run_slot(1'b1, 1'b1, 8'hC3, 1, 19);

    // reset in the middle of a byte
    run_slot(1'b0, 1'b0, 8'h96, 0, 8);
    @(negedge sys_clk);
    scnt  = 5'd9;
    reset = 1'b1;
    #1;
    check("midreset cs", {7'd0, cs}, 8'h01);
    check("midreset sda", {7'd0, sda}, 8'h00);
    @(posedge sys_clk);
    #1;
    check("midreset hold cs", {7'd0, cs}, 8'h01);
    @(negedge sys_clk);
    reset = 1'b0;
    for (int s = 10; s <= 19; s++) cyc(5'(s), 1'b0, 8'h96, 1'b1, 1'b0);
    run_slot(1'b0, 1'b0, 8'h3C, 0, 19);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
